// File: rtl/mtl_motion_pkg.sv
// Shared types and helpers for the MTL ball-motion generator: FSM states,
// host command codes, coordinate/velocity types and velocity arithmetic.
package mtl_motion_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP_X = 2'd1,
        STEP_Y = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SET_POS = 2'd0,
        SET_VEL = 2'd1,
        IMPULSE = 2'd2,
        STOP    = 2'd3
    } cmd_t;

    typedef logic [9:0]        coord_x_t;
    typedef logic [8:0]        coord_y_t;
    typedef logic signed [5:0] vel_t;

    // Wide enough for the sum of a saturated velocity and a raw 6-bit command value.
    function automatic vel_t sat_vel(input logic signed [6:0] raw, input int vmax);
        if (raw > vmax)
            return vel_t'(vmax);
        else if (raw < -vmax)
            return vel_t'(-vmax);
        else
            return vel_t'(raw);
    endfunction

    function automatic vel_t toward_zero(input vel_t v);
        if (v > 0)
            return v - vel_t'(1);
        else if (v < 0)
            return v + vel_t'(1);
        else
            return v;
    endfunction

endpackage

// File: rtl/mtl_axis_reflect.sv
// One-axis position step with single reflection at the MIN/MAX walls.
// Shared between x and y; y callers zero-extend their position and limits.
module mtl_axis_reflect
    import mtl_motion_pkg::*;
(
    input  logic [9:0] iP,
    input  vel_t       iV,
    input  logic [9:0] iMin,
    input  logic [9:0] iMax,
    output logic [9:0] oP,
    output vel_t       oV,
    output logic       oHit
);

    logic signed [11:0] n;
    logic signed [11:0] lo;
    logic signed [11:0] hi;
    logic signed [11:0] r;

    always_comb begin
        n    = $signed({2'b00, iP}) + $signed({{6{iV[5]}}, iV});
        lo   = $signed({2'b00, iMin});
        hi   = $signed({2'b00, iMax});
        r    = n;
        oHit = 1'b0;
        if (n > hi) begin
            r    = (hi <<< 1) - n;
            oHit = 1'b1;
        end else if (n < lo) begin
            r    = (lo <<< 1) - n;
            oHit = 1'b1;
        end
        oP = r[9:0];
        oV = oHit ? -iV : iV;
    end

endmodule

// File: rtl/mtl_ball_motion.sv
// Per-frame ball position generator for the MTL display controller: host commands
// update a working position/velocity; the displayed position latches only at frame start.
module mtl_ball_motion
    import mtl_motion_pkg::*;
#(
    parameter int X_MIN           = 66,
    parameter int X_MAX           = 825,
    parameter int Y_MIN           = 43,
    parameter int Y_MAX           = 482,
    parameter int X_INIT          = 446,
    parameter int Y_INIT          = 263,
    parameter int VMAX            = 15,
    parameter int FRICTION_FRAMES = 0
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic       iEndFrame,
    input  logic       iNewFrame,
    input  logic       iCmdValid,
    output logic       oCmdReady,
    input  logic [1:0] iCmdType,
    input  logic [9:0] iCmdX,
    input  logic [8:0] iCmdY,
    output logic [9:0] oX,
    output logic [8:0] oY,
    output logic       oBounce,
    output state_t     oState
);

    localparam coord_x_t XMIN_C  = coord_x_t'(X_MIN);
    localparam coord_x_t XMAX_C  = coord_x_t'(X_MAX);
    localparam coord_y_t YMIN_C  = coord_y_t'(Y_MIN);
    localparam coord_y_t YMAX_C  = coord_y_t'(Y_MAX);
    localparam coord_x_t XINIT_C = coord_x_t'(X_INIT);
    localparam coord_y_t YINIT_C = coord_y_t'(Y_INIT);

    state_t      state, nextState;
    coord_x_t    posX;
    coord_y_t    posY;
    vel_t        velX, velY;
    logic        pending;
    logic        hitX;
    logic [15:0] frameCnt;

    logic [9:0]  refP, refMin, refMax, refPOut;
    vel_t        refV, refVOut;
    logic        refHit;

    logic [15:0] cntInc;
    logic        frictionNow;
    logic        cmdFire;
    vel_t        cmdVX, cmdVY;
    logic signed [6:0] sumX, sumY;

    // Handshake: a command transfers on a rising iCLK edge where iCmdValid && oCmdReady;
    // the host holds iCmdValid and the payload stable until then. Frame steps take priority.
    assign oCmdReady = iRST_n && (state == IDLE) && !iEndFrame;
    assign cmdFire   = iCmdValid && oCmdReady;
    assign oState    = state;

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (iEndFrame) nextState = STEP_X;
            STEP_X:  nextState = STEP_Y;
            STEP_Y:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        refP   = posX;
        refV   = velX;
        refMin = XMIN_C;
        refMax = XMAX_C;
        if (state == STEP_Y) begin
            refP   = {1'b0, posY};
            refV   = velY;
            refMin = {1'b0, YMIN_C};
            refMax = {1'b0, YMAX_C};
        end
    end

    mtl_axis_reflect uReflect (
        .iP   (refP),
        .iV   (refV),
        .iMin (refMin),
        .iMax (refMax),
        .oP   (refPOut),
        .oV   (refVOut),
        .oHit (refHit)
    );

    always_comb begin
        cntInc      = frameCnt + 16'd1;
        frictionNow = (FRICTION_FRAMES != 0) && (cntInc == 16'(FRICTION_FRAMES));
        cmdVX       = vel_t'(iCmdX[5:0]);
        cmdVY       = vel_t'(iCmdY[5:0]);
        sumX        = $signed({velX[5], velX}) + $signed({cmdVX[5], cmdVX});
        sumY        = $signed({velY[5], velY}) + $signed({cmdVY[5], cmdVY});
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state    <= IDLE;
            posX     <= XINIT_C;
            posY     <= YINIT_C;
            velX     <= '0;
            velY     <= '0;
            pending  <= 1'b0;
            hitX     <= 1'b0;
            frameCnt <= '0;
            oX       <= XINIT_C;
            oY       <= YINIT_C;
            oBounce  <= 1'b0;
        end else begin
            state   <= nextState;
            oBounce <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (iNewFrame && pending) begin
                        oX      <= posX;
                        oY      <= posY;
                        pending <= 1'b0;
                    end
                    // A command landing on the publish cycle stays pending for the next frame.
                    if (cmdFire) begin
                        pending <= 1'b1;
                        unique case (cmd_t'(iCmdType))
                            SET_POS: begin
                                posX <= (iCmdX < XMIN_C) ? XMIN_C : (iCmdX > XMAX_C) ? XMAX_C : iCmdX;
                                posY <= (iCmdY < YMIN_C) ? YMIN_C : (iCmdY > YMAX_C) ? YMAX_C : iCmdY;
                            end
                            SET_VEL: begin
                                velX <= sat_vel({cmdVX[5], cmdVX}, VMAX);
                                velY <= sat_vel({cmdVY[5], cmdVY}, VMAX);
                            end
                            IMPULSE: begin
                                velX <= sat_vel(sumX, VMAX);
                                velY <= sat_vel(sumY, VMAX);
                            end
                            STOP: begin
                                velX <= '0;
                                velY <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                STEP_X: begin
                    posX <= refPOut;
                    velX <= refVOut;
                    hitX <= refHit;
                end
                STEP_Y: begin
                    posY     <= refPOut[8:0];
                    velY     <= frictionNow ? toward_zero(refVOut) : refVOut;
                    velX     <= frictionNow ? toward_zero(velX) : velX;
                    frameCnt <= frictionNow ? 16'd0 : cntInc;
                    pending  <= 1'b1;
                    oBounce  <= hitX | refHit;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mtl_ball_motion.sv
// Bench for mtl_ball_motion: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a frame-level behavioural model.
module tb_mtl_ball_motion;
    import mtl_motion_pkg::*;

    localparam int X_MIN = 66;
    localparam int X_MAX = 825;
    localparam int Y_MIN = 43;
    localparam int Y_MAX = 482;
    localparam int X_INIT = 446;
    localparam int Y_INIT = 263;
    localparam int VMAX = 15;
    localparam int FF = 4;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       iRST_n;
    logic       iEndFrame, iNewFrame, iCmdValid;
    logic       oCmdReady;
    logic [1:0] iCmdType;
    logic [9:0] iCmdX;
    logic [8:0] iCmdY;
    logic [9:0] oX;
    logic [8:0] oY;
    logic       oBounce;
    state_t     oState;

    mtl_ball_motion #(
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .X_INIT(X_INIT), .Y_INIT(Y_INIT), .VMAX(VMAX), .FRICTION_FRAMES(FF)
    ) dut (
        .iCLK(clk), .iRST_n(iRST_n), .iEndFrame(iEndFrame), .iNewFrame(iNewFrame),
        .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdType(iCmdType),
        .iCmdX(iCmdX), .iCmdY(iCmdY), .oX(oX), .oY(oY), .oBounce(oBounce), .oState(oState)
    );

    int nChecks = 0;
    int nErrors = 0;
    bit checkEn = 0;

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: the whole frame step is computed at once when the busy window ends
    typedef struct packed {
        int px; int py; int vx; int vy; int pend;
        int dx; int dy; int busy; int bounce; int cnt;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.px = X_INIT; r.py = Y_INIT; r.vx = 0; r.vy = 0; r.pend = 0;
        r.dx = X_INIT; r.dy = Y_INIT; r.busy = 0; r.bounce = 0; r.cnt = 0;
        return r;
    endfunction

    function automatic int sx6(input int raw);
        int s = raw & 63;
        return (s >= 32) ? s - 64 : s;
    endfunction

    function automatic int clip(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic int toward0(input int v);
        return (v > 0) ? v - 1 : (v < 0) ? v + 1 : v;
    endfunction

    function automatic bit outside(input int p, input int v, input int lo, input int hi);
        return (p + v > hi) || (p + v < lo);
    endfunction

    function automatic int bounce_pos(input int p, input int v, input int lo, input int hi);
        int n = p + v;
        if (n > hi) return 2 * hi - n;
        if (n < lo) return 2 * lo - n;
        return n;
    endfunction

    function automatic model_t model_next(input model_t s, input logic ef, input logic nf,
                                          input logic cv, input logic [1:0] ct,
                                          input logic [9:0] cx, input logic [8:0] cy);
        model_t r = s;
        bit hx, hy;
        r.bounce = 0;
        if (s.busy > 0) begin
            r.busy = s.busy - 1;
            if (r.busy == 0) begin
                hx = outside(s.px, s.vx, X_MIN, X_MAX);
                hy = outside(s.py, s.vy, Y_MIN, Y_MAX);
                r.px = bounce_pos(s.px, s.vx, X_MIN, X_MAX);
                r.py = bounce_pos(s.py, s.vy, Y_MIN, Y_MAX);
                r.vx = hx ? -s.vx : s.vx;
                r.vy = hy ? -s.vy : s.vy;
                r.cnt = s.cnt + 1;
                if (FF != 0 && r.cnt == FF) begin
                    r.cnt = 0;
                    r.vx = toward0(r.vx);
                    r.vy = toward0(r.vy);
                end
                r.pend = 1;
                r.bounce = (hx || hy) ? 1 : 0;
            end
        end else begin
            if (nf && s.pend != 0) begin
                r.dx = s.px;
                r.dy = s.py;
                r.pend = 0;
            end
            if (ef) begin
                r.busy = 2;
            end else if (cv) begin
                r.pend = 1;
                case (ct)
                    2'd0: begin r.px = clip(int'(cx), X_MIN, X_MAX); r.py = clip(int'(cy), Y_MIN, Y_MAX); end
                    2'd1: begin r.vx = clip(sx6(int'(cx)), -VMAX, VMAX); r.vy = clip(sx6(int'(cy)), -VMAX, VMAX); end
                    2'd2: begin r.vx = clip(s.vx + sx6(int'(cx)), -VMAX, VMAX); r.vy = clip(s.vy + sx6(int'(cy)), -VMAX, VMAX); end
                    default: begin r.vx = 0; r.vy = 0; end
                endcase
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge iRST_n) begin
        if (!iRST_n) m <= model_reset();
        else         m <= model_next(m, iEndFrame, iNewFrame, iCmdValid, iCmdType, iCmdX, iCmdY);
    end

    // scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (checkEn) begin
            chk("oX", int'(oX), m.dx);
            chk("oY", int'(oY), m.dy);
            chk("oBounce", int'(oBounce), m.bounce);
            chk("oCmdReady", int'(oCmdReady), (iRST_n && m.busy == 0 && !iEndFrame) ? 1 : 0);
            chk("oState", int'(oState), (m.busy == 0) ? int'(IDLE) : (m.busy == 2) ? int'(STEP_X) : int'(STEP_Y));
        end
    end

    // driver tasks
    task automatic do_reset();
        @(posedge clk); #1;
        iRST_n = 1'b0; iEndFrame = 1'b0; iNewFrame = 1'b0; iCmdValid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        iRST_n = 1'b1;
    endtask

    task automatic do_cmd(input logic [1:0] t, input logic [9:0] x, input logic [8:0] y);
        bit acc = 0;
        @(posedge clk); #1;
        iCmdValid = 1'b1; iCmdType = t; iCmdX = x; iCmdY = y;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (oCmdReady) begin
                acc = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("cmd_accept", int'(acc), 1);
        @(posedge clk); #1;
        iCmdValid = 1'b0;
    endtask

    task automatic pulse_new();
        @(posedge clk); #1; iNewFrame = 1'b1;
        @(posedge clk); #1; iNewFrame = 1'b0;
    endtask

    task automatic run_frame(output logic [4:0] bm);
        @(posedge clk); #1; iEndFrame = 1'b1;
        @(negedge clk); bm[0] = oBounce;
        @(posedge clk); #1; iEndFrame = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk); bm[k] = oBounce;
            if (k < 4) begin @(posedge clk); #1; end
        end
        pulse_new();
    endtask

    logic [4:0] bm;
    int waits;
    bit lastReady;
    int flen, endAt, pos;

    initial begin
        iRST_n = 1'b0; iEndFrame = 1'b0; iNewFrame = 1'b0; iCmdValid = 1'b0;
        iCmdType = 2'd0; iCmdX = '0; iCmdY = '0;
        repeat (3) @(posedge clk);
        #1 iRST_n = 1'b1;
        checkEn = 1;

        @(negedge clk);
        chk("reset_x", int'(oX), 446);
        chk("reset_y", int'(oY), 263);
        chk("reset_ready", int'(oCmdReady), 1);
        chk("reset_bounce", int'(oBounce), 0);

        // plain motion: v = (+5, -3)
        do_cmd(2'd1, 10'd5, 9'h1FD);
        run_frame(bm);
        @(negedge clk);
        chk("move_x", int'(oX), 451);
        chk("move_y", int'(oY), 260);

        // right-wall reflection
        do_reset();
        do_cmd(2'd0, 10'd823, 9'd263);
        do_cmd(2'd1, 10'd5, 9'd0);
        run_frame(bm);
        @(negedge clk);
        chk("bounce_x", int'(oX), 822);
        chk("bounce_pulse", int'(bm), 8);
        run_frame(bm);
        @(negedge clk);
        chk("after_bounce_x", int'(oX), 817);
        chk("after_bounce_y", int'(oY), 263);

        // velocity saturation in both directions
        do_reset();
        do_cmd(2'd1, 10'd14, 9'd50);
        do_cmd(2'd2, 10'd6, 9'd58);
        run_frame(bm);
        @(negedge clk);
        chk("sat_x", int'(oX), 461);
        chk("sat_y", int'(oY), 248);

        // position clamping
        do_cmd(2'd0, 10'd1000, 9'd0);
        pulse_new();
        @(negedge clk);
        chk("clamp_x", int'(oX), 825);
        chk("clamp_y", int'(oY), 43);

        // command colliding with a frame step
        @(posedge clk); #1;
        iEndFrame = 1'b1; iCmdValid = 1'b1; iCmdType = 2'd0; iCmdX = 10'd500; iCmdY = 9'd300;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (oCmdReady) break;
            waits++;
            @(posedge clk); #1;
            iEndFrame = 1'b0;
        end
        chk("collide_wait", waits, 3);
        @(posedge clk); #1;
        iCmdValid = 1'b0;
        pulse_new();
        @(negedge clk);
        chk("collide_x", int'(oX), 500);
        chk("collide_y", int'(oY), 300);

        // friction every fourth frame
        do_reset();
        do_cmd(2'd1, 10'd3, 9'd0);
        repeat (5) run_frame(bm);
        @(negedge clk);
        chk("friction_x", int'(oX), 460);

        // reset while stepping
        do_cmd(2'd0, 10'd600, 9'd400);
        do_cmd(2'd1, 10'd7, 9'd7);
        pulse_new();
        @(posedge clk); #1; iEndFrame = 1'b1;
        @(posedge clk); #1; iEndFrame = 1'b0;
        chk("midstep_state", int'(oState), int'(STEP_X));
        iRST_n = 1'b0;
        #1;
        chk("midstep_rst_x", int'(oX), 446);
        chk("midstep_rst_ready", int'(oCmdReady), 0);
        chk("midstep_rst_state", int'(oState), int'(IDLE));
        @(posedge clk); #1; iRST_n = 1'b1;
        run_frame(bm);
        @(negedge clk);
        chk("post_rst_x", int'(oX), 446);
        chk("post_rst_y", int'(oY), 263);

        // randomized frames and commands
        do_reset();
        pos = 0; flen = 12; endAt = 5;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            lastReady = oCmdReady;
            @(posedge clk); #1;
            if (iCmdValid && lastReady) iCmdValid = 1'b0;
            if (pos == 0) begin
                flen  = $urandom_range(6, 20);
                endAt = $urandom_range(1, flen - 1);
            end
            iNewFrame = (pos == 0);
            iEndFrame = (pos == endAt);
            pos = (pos + 1 == flen) ? 0 : pos + 1;
            if (!iCmdValid && $urandom_range(0, 3) == 0) begin
                iCmdValid = 1'b1;
                iCmdType  = 2'($urandom_range(0, 3));
                iCmdX     = 10'($urandom_range(0, 1023));
                iCmdY     = 9'($urandom_range(0, 511));
            end
            if (c == 1500) iRST_n = 1'b0;
            if (c == 1502) iRST_n = 1'b1;
        end
        @(posedge clk); #1;
        iCmdValid = 1'b0; iEndFrame = 1'b0; iNewFrame = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkEn = 0;

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
